execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the five-stage pipeline. It consumes the execute-stage operand and control bundle (`x_*`) from the decode-to-execute register and computes the ALU result, memory address and branch/jump redirect. It also runs a 32-iteration shift-add multiplier that stalls the front end, and registers results and controls into the memory stage (`m_*`).

## Interface
- No parameters; data width is fixed at 32 bits.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `x_pc` in 32: PC of the instruction in execute.
- `x_opcode` in 7: operation code.
- `x_dst_reg` in 5: destination register index.
- `x_mem_offset` in 32: M-type / immediate offset.
- `x_brn_offset` in 32: branch offset.
- `x_jmp_offset` in 20: jump offset, two's complement.
- `x_read_data_1`, `x_read_data_2` in 32 each: source operands A and R2.
- `x_alu_imm_src`, `x_mem_read`, `x_mem_write`, `x_mem_byte`, `x_reg_write`, `x_mem_to_reg` in 1 each: control flags.
- `x_stall` out 1: combinational. While high, upstream registers hold.
- `x_branch_taken` out 1: combinational redirect request.
- `x_branch_target` out 32: combinational redirect PC.
- `m_alu_result` out 32: registered result or address.
- `m_store_data` out 32: registered `x_read_data_2`.
- `m_dst_reg` out 5: registered destination register index.
- `m_mem_read`, `m_mem_write`, `m_mem_byte`, `m_reg_write`, `m_mem_to_reg` out 1 each: registered controls.

## Operation
- Operand B = `x_alu_imm_src` ? `x_mem_offset` : `x_read_data_2`.
- Opcode 0x00 ADD: result = A+B, mod 2^32.
- Opcode 0x01 SUB: result = A−B, mod 2^32.
- Opcode 0x02 MUL: low 32 bits of A×B, produced by the multiplier FSM.
- Opcodes 0x10 LOAD and 0x11 STORE: result = A + `x_mem_offset`, the memory address.
- Opcode 0x30 BEQ: `x_branch_taken` = (A == `x_read_data_2`); target = `x_pc` + `x_brn_offset`.
- Opcode 0x31 JUMP: `x_branch_taken` = 1; target = `x_pc` + sign-extend(`x_jmp_offset`).
- Any other opcode: result = 0.
- `x_branch_target` is 0 whenever `x_branch_taken` is 0. Flushing younger instructions is not done in this block.
- Multiplier FSM has three states: IDLE, BUSY and DONE, plus a 5-bit counter.
  - IDLE with opcode MUL: latch multiplicand = A, multiplier = B, accumulator = 0, counter = 0; go to BUSY.
  - BUSY, each cycle: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++. After the counter-31 iteration, go to DONE.
  - DONE: drive `m_alu_result` = accumulator and the `x_*` controls (still held upstream) into the `m_*` registers; go to IDLE.
- `x_stall` = (IDLE and opcode==MUL) or BUSY. It is low in DONE.
- While `x_stall` is high, the `m_*` registers load a bubble: all control outputs 0, data outputs 0, `m_dst_reg` 0.
- In every non-stalled cycle, the `m_*` registers load the current result, `x_read_data_2`, `x_dst_reg` and the controls unchanged.

## Timing
- Reset asserted (asynchronous) forces:
  - FSM to IDLE, counter to 0, multiplier datapath registers to 0.
  - Every `m_*` output to 0.
  - Combinational outputs then follow the inputs.
- Reset asserted mid-multiply aborts the multiply; no partial result is ever emitted. After release, a MUL still present on the inputs restarts from IDLE.
- Non-MUL ops: one cycle of latency; `m_*` is valid on the edge after the inputs are presented.
- MUL, counting from the first cycle it is presented in IDLE:
  - `x_stall` is high for exactly 33 cycles: 1 IDLE cycle plus 32 BUSY cycles.
  - DONE occupies cycle 34.
  - The result appears on `m_*` after the edge ending cycle 34, on the same edge that the upstream register advances.
- Back-to-back MULs: the second MUL is seen in IDLE in the cycle after DONE and starts a fresh 33-cycle stall. There are no idle gaps beyond that.
- Branch outputs are purely combinational on the current `x_*` inputs and are valid in the same cycle.
- The `m_*` registers record branches and jumps with their controls as given; the controls are expected to be 0.

## Test plan
- Reset low with random inputs -> all `m_*` = 0 and FSM in IDLE. Release reset with ADD, A=5, R2=7, imm_src=0, reg_write=1, dst=3 -> next edge: `m_alu_result`=12, `m_reg_write`=1, `m_dst_reg`=3.
- SUB with A=3, imm_src=1, mem_offset=5 -> `m_alu_result`=0xFFFFFFFE.
- STORE with A=0x100, mem_offset=0xFFFFFFFC, R2=0xAB, mem_write=1 -> `m_alu_result`=0xFC, `m_store_data`=0xAB, `m_mem_write`=1.
- MUL 7×6 with reg_write=1 -> `x_stall` high for exactly 33 cycles and `m_*` controls 0 throughout; then `m_alu_result`=42, `m_reg_write`=1. Repeat with 0xFFFFFFFF×3 -> 0xFFFFFFFD.
- BEQ with PC=0x40, A=R2=9, brn_offset=0x10 -> taken=1, target=0x50. With A≠R2 -> taken=0, target=0. JUMP with PC=0x40, jmp_offset=0xFFFF0 -> target=0x30.
- MUL started, reset pulsed low at BUSY counter=10 -> `x_stall` and all `m_*` immediately 0. After release with MUL 4×4 held -> full 33-cycle stall, result 16.

Source files
------------

// File: rtl/execute_stage_if.sv
// Execute-stage bundle: x_* operands/controls in, combinational redirect/stall
// out, and the registered m_* bundle toward the memory stage.
interface execute_stage_if;
  logic [31:0] x_pc;
  logic [6:0]  x_opcode;
  logic [4:0]  x_dst_reg;
  logic [31:0] x_mem_offset;
  logic [31:0] x_brn_offset;
  logic [19:0] x_jmp_offset;
  logic [31:0] x_read_data_1;
  logic [31:0] x_read_data_2;
  logic        x_alu_imm_src;
  logic        x_mem_read;
  logic        x_mem_write;
  logic        x_mem_byte;
  logic        x_reg_write;
  logic        x_mem_to_reg;
  logic        x_stall;
  logic        x_branch_taken;
  logic [31:0] x_branch_target;
  logic [31:0] m_alu_result;
  logic [31:0] m_store_data;
  logic [4:0]  m_dst_reg;
  logic        m_mem_read;
  logic        m_mem_write;
  logic        m_mem_byte;
  logic        m_reg_write;
  logic        m_mem_to_reg;

  // Upstream side: drives the decode-to-execute bundle, observes the results.
  modport master (
    output x_pc, x_opcode, x_dst_reg, x_mem_offset, x_brn_offset, x_jmp_offset,
           x_read_data_1, x_read_data_2, x_alu_imm_src, x_mem_read, x_mem_write,
           x_mem_byte, x_reg_write, x_mem_to_reg,
    input  x_stall, x_branch_taken, x_branch_target, m_alu_result, m_store_data,
           m_dst_reg, m_mem_read, m_mem_write, m_mem_byte, m_reg_write, m_mem_to_reg
  );

  // Execute-stage side.
  modport slave (
    input  x_pc, x_opcode, x_dst_reg, x_mem_offset, x_brn_offset, x_jmp_offset,
           x_read_data_1, x_read_data_2, x_alu_imm_src, x_mem_read, x_mem_write,
           x_mem_byte, x_reg_write, x_mem_to_reg,
    output x_stall, x_branch_taken, x_branch_target, m_alu_result, m_store_data,
           m_dst_reg, m_mem_read, m_mem_write, m_mem_byte, m_reg_write, m_mem_to_reg
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, address generation, branch/jump redirect and a 32-step
// shift-add multiplier that stalls the front end, registered into m_*.
module execute_stage (
  input  logic            clock,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  localparam logic [6:0] OP_ADD   = 7'h00;
  localparam logic [6:0] OP_SUB   = 7'h01;
  localparam logic [6:0] OP_MUL   = 7'h02;
  localparam logic [6:0] OP_LOAD  = 7'h10;
  localparam logic [6:0] OP_STORE = 7'h11;
  localparam logic [6:0] OP_BEQ   = 7'h30;
  localparam logic [6:0] OP_JUMP  = 7'h31;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  mul_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;

  logic [31:0] m_alu_result_q, m_alu_result_d;
  logic [31:0] m_store_data_q, m_store_data_d;
  logic [4:0]  m_dst_reg_q, m_dst_reg_d;
  logic [4:0]  m_ctrl_q, m_ctrl_d;

  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        stall;
  logic        taken;
  logic [31:0] target;

  // Single-cycle ALU and address generation.
  always_comb begin
    op_b = bus.x_alu_imm_src ? bus.x_mem_offset : bus.x_read_data_2;
    alu_result = '0;
    case (bus.x_opcode)
      OP_ADD:             alu_result = bus.x_read_data_1 + op_b;
      OP_SUB:             alu_result = bus.x_read_data_1 - op_b;
      OP_LOAD, OP_STORE:  alu_result = bus.x_read_data_1 + bus.x_mem_offset;
      default:            alu_result = '0;
    endcase
  end

  // Branch/jump redirect, purely combinational on the current inputs.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (bus.x_opcode)
      OP_BEQ: begin
        taken  = (bus.x_read_data_1 == bus.x_read_data_2);
        target = taken ? bus.x_pc + bus.x_brn_offset : '0;
      end
      OP_JUMP: begin
        taken  = 1'b1;
        target = bus.x_pc + {{12{bus.x_jmp_offset[19]}}, bus.x_jmp_offset};
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  // Multiplier next-state, datapath and stall generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.x_opcode == OP_MUL) begin
          stall    = 1'b1;
          mcand_d  = bus.x_read_data_1;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next m_* bundle: a bubble while stalled, the product in DONE, else the ALU.
  always_comb begin
    m_alu_result_d = '0;
    m_store_data_d = '0;
    m_dst_reg_d    = '0;
    m_ctrl_d       = '0;
    if (!stall) begin
      m_alu_result_d = (state_q == DONE) ? acc_q : alu_result;
      m_store_data_d = bus.x_read_data_2;
      m_dst_reg_d    = bus.x_dst_reg;
      m_ctrl_d       = {bus.x_mem_read, bus.x_mem_write, bus.x_mem_byte,
                        bus.x_reg_write, bus.x_mem_to_reg};
    end
  end

  // Multiplier state and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Execute-to-memory pipeline register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_alu_result_q <= '0;
      m_store_data_q <= '0;
      m_dst_reg_q    <= '0;
      m_ctrl_q       <= '0;
    end else begin
      m_alu_result_q <= m_alu_result_d;
      m_store_data_q <= m_store_data_d;
      m_dst_reg_q    <= m_dst_reg_d;
      m_ctrl_q       <= m_ctrl_d;
    end
  end

  // Stall is masked while reset is held so an aborted MUL releases the front end.
  assign bus.x_stall         = stall & reset;
  assign bus.x_branch_taken  = taken;
  assign bus.x_branch_target = target;
  assign bus.m_alu_result    = m_alu_result_q;
  assign bus.m_store_data    = m_store_data_q;
  assign bus.m_dst_reg       = m_dst_reg_q;
  assign bus.m_mem_read      = m_ctrl_q[4];
  assign bus.m_mem_write     = m_ctrl_q[3];
  assign bus.m_mem_byte      = m_ctrl_q[2];
  assign bus.m_reg_write     = m_ctrl_q[1];
  assign bus.m_mem_to_reg    = m_ctrl_q[0];

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed and randomized ALU, branch,
// multiplier and reset scenarios against a behavioural reference model.
module tb_execute_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;

  execute_stage_if bus();

  execute_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference ALU result from the operation table.
  function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] a,
                                             input logic [31:0] r2, input logic imm,
                                             input logic [31:0] off);
    logic [31:0] b;
    b = imm ? off : r2;
    case (op)
      7'h00:        return a + b;
      7'h01:        return a - b;
      7'h10, 7'h11: return a + off;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] cur_ctrl();
    return {bus.x_mem_read, bus.x_mem_write, bus.x_mem_byte, bus.x_reg_write, bus.x_mem_to_reg};
  endfunction

  function automatic logic [4:0] m_ctrl();
    return {bus.m_mem_read, bus.m_mem_write, bus.m_mem_byte, bus.m_reg_write, bus.m_mem_to_reg};
  endfunction

  function automatic logic m_all_zero();
    return (bus.m_alu_result === 32'd0) && (bus.m_store_data === 32'd0) &&
           (bus.m_dst_reg === 5'd0) && (m_ctrl() === 5'd0);
  endfunction

  task automatic rand_inputs(input logic [6:0] op);
    bus.x_pc          = $urandom;
    bus.x_opcode      = op;
    bus.x_dst_reg     = 5'($urandom);
    bus.x_mem_offset  = $urandom;
    bus.x_brn_offset  = $urandom;
    bus.x_jmp_offset  = 20'($urandom);
    bus.x_read_data_1 = $urandom;
    bus.x_read_data_2 = $urandom;
    bus.x_alu_imm_src = 1'($urandom);
    bus.x_mem_read    = 1'($urandom);
    bus.x_mem_write   = 1'($urandom);
    bus.x_mem_byte    = 1'($urandom);
    bus.x_reg_write   = 1'($urandom);
    bus.x_mem_to_reg  = 1'($urandom);
  endtask

  task automatic test_reset();
    rand_inputs(7'($urandom));
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (!m_all_zero()) begin
      n_err++;
      $display("FAIL reset_m_zero: got res=%h sd=%h dst=%h ctl=%b, want all 0",
               bus.m_alu_result, bus.m_store_data, bus.m_dst_reg, m_ctrl());
    end
    n_cmp++;
    if (bus.x_stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall: got %b want 0", bus.x_stall);
    end
    rand_inputs(7'h00);
    bus.x_read_data_1 = 32'd5;
    bus.x_read_data_2 = 32'd7;
    bus.x_alu_imm_src = 1'b0;
    bus.x_reg_write   = 1'b1;
    bus.x_dst_reg     = 5'd3;
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.m_alu_result !== 32'd12 || bus.m_reg_write !== 1'b1 || bus.m_dst_reg !== 5'd3) begin
      n_err++;
      $display("FAIL first_add: got res=%0d rw=%b dst=%0d want 12 1 3",
               bus.m_alu_result, bus.m_reg_write, bus.m_dst_reg);
    end
  endtask

  task automatic test_directed_alu();
    rand_inputs(7'h01);
    bus.x_read_data_1 = 32'd3;
    bus.x_alu_imm_src = 1'b1;
    bus.x_mem_offset  = 32'd5;
    @(negedge clock);
    n_cmp++;
    if (bus.m_alu_result !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL sub_imm: got %h want fffffffe", bus.m_alu_result);
    end
    rand_inputs(7'h11);
    bus.x_read_data_1 = 32'h100;
    bus.x_mem_offset  = 32'hFFFF_FFFC;
    bus.x_read_data_2 = 32'hAB;
    bus.x_mem_write   = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.m_alu_result !== 32'hFC || bus.m_store_data !== 32'hAB || bus.m_mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL store: got addr=%h sd=%h mw=%b want fc ab 1",
               bus.m_alu_result, bus.m_store_data, bus.m_mem_write);
    end
  endtask

  task automatic test_alu_random();
    logic [6:0]  ops [7] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h30, 7'h31, 7'h05};
    logic [31:0] e_res, e_sd;
    logic [4:0]  e_dst, e_ctl;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(ops[$urandom_range(0, 6)]);
      e_res = ref_result(bus.x_opcode, bus.x_read_data_1, bus.x_read_data_2,
                         bus.x_alu_imm_src, bus.x_mem_offset);
      e_sd  = bus.x_read_data_2;
      e_dst = bus.x_dst_reg;
      e_ctl = cur_ctrl();
      #1;
      n_cmp++;
      if (bus.x_stall !== 1'b0) begin
        n_err++;
        $display("FAIL alu_stall[%0d]: got %b want 0", i, bus.x_stall);
      end
      @(negedge clock);
      n_cmp++;
      if (bus.m_alu_result !== e_res || bus.m_store_data !== e_sd ||
          bus.m_dst_reg !== e_dst || m_ctrl() !== e_ctl) begin
        n_err++;
        $display("FAIL alu_rand[%0d]: got res=%h sd=%h dst=%h ctl=%b want %h %h %h %b", i,
                 bus.m_alu_result, bus.m_store_data, bus.m_dst_reg, m_ctrl(),
                 e_res, e_sd, e_dst, e_ctl);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] e_tgt;
    logic        e_tk;
    rand_inputs(7'h30);
    bus.x_pc = 32'h40; bus.x_read_data_1 = 32'd9; bus.x_read_data_2 = 32'd9;
    bus.x_brn_offset = 32'h10;
    #1;
    n_cmp++;
    if (bus.x_branch_taken !== 1'b1 || bus.x_branch_target !== 32'h50) begin
      n_err++;
      $display("FAIL beq_taken: got %b %h want 1 00000050", bus.x_branch_taken, bus.x_branch_target);
    end
    bus.x_read_data_2 = 32'd8;
    #1;
    n_cmp++;
    if (bus.x_branch_taken !== 1'b0 || bus.x_branch_target !== 32'h0) begin
      n_err++;
      $display("FAIL beq_not_taken: got %b %h want 0 0", bus.x_branch_taken, bus.x_branch_target);
    end
    bus.x_opcode = 7'h31; bus.x_jmp_offset = 20'hFFFF0;
    #1;
    n_cmp++;
    if (bus.x_branch_taken !== 1'b1 || bus.x_branch_target !== 32'h30) begin
      n_err++;
      $display("FAIL jump_back: got %b %h want 1 00000030", bus.x_branch_taken, bus.x_branch_target);
    end
    for (int i = 0; i < 20; i++) begin
      rand_inputs(7'($urandom_range(0, 3) == 0 ? $urandom : 32'h30 + $urandom_range(0, 1)));
      if (bus.x_opcode == 7'h02) bus.x_opcode = 7'h30;
      if ($urandom_range(0, 1) == 1) bus.x_read_data_2 = bus.x_read_data_1;
      e_tk = 1'b0; e_tgt = 32'd0;
      if (bus.x_opcode == 7'h30 && bus.x_read_data_1 == bus.x_read_data_2) begin
        e_tk = 1'b1; e_tgt = bus.x_pc + bus.x_brn_offset;
      end else if (bus.x_opcode == 7'h31) begin
        e_tk  = 1'b1;
        e_tgt = (bus.x_jmp_offset >= 20'h80000)
                ? bus.x_pc + 32'(bus.x_jmp_offset) - 32'h0010_0000
                : bus.x_pc + 32'(bus.x_jmp_offset);
      end
      #1;
      n_cmp++;
      if (bus.x_branch_taken !== e_tk || bus.x_branch_target !== e_tgt) begin
        n_err++;
        $display("FAIL branch_rand[%0d]: op=%h got %b %h want %b %h", i, bus.x_opcode,
                 bus.x_branch_taken, bus.x_branch_target, e_tk, e_tgt);
      end
      @(negedge clock);
    end
  endtask

  // Presents a MUL at the current negedge and follows it through to the result.
  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic imm,
                          input string name);
    logic [31:0] e_prod, e_sd;
    logic [4:0]  e_dst, e_ctl;
    int unsigned stall_cnt;
    logic        bubble_bad;
    rand_inputs(7'h02);
    bus.x_read_data_1 = a;
    bus.x_alu_imm_src = imm;
    if (imm) bus.x_mem_offset = b; else bus.x_read_data_2 = b;
    bus.x_reg_write = 1'b1;
    e_prod = a * b;
    e_sd   = bus.x_read_data_2;
    e_dst  = bus.x_dst_reg;
    e_ctl  = cur_ctrl();
    #1;
    stall_cnt  = 0;
    bubble_bad = 1'b0;
    while (bus.x_stall === 1'b1 && stall_cnt < 100) begin
      stall_cnt++;
      @(negedge clock);
      if (!m_all_zero()) bubble_bad = 1'b1;
    end
    n_cmp++;
    if (stall_cnt != 33) begin
      n_err++;
      $display("FAIL %s_stall_len: got %0d cycles want 33", name, stall_cnt);
    end
    n_cmp++;
    if (bubble_bad) begin
      n_err++;
      $display("FAIL %s_bubble: got nonzero m_* during stall want all 0", name);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.m_alu_result !== e_prod || bus.m_store_data !== e_sd ||
        bus.m_dst_reg !== e_dst || m_ctrl() !== e_ctl) begin
      n_err++;
      $display("FAIL %s_result: got res=%h sd=%h dst=%h ctl=%b want %h %h %h %b", name,
               bus.m_alu_result, bus.m_store_data, bus.m_dst_reg, m_ctrl(),
               e_prod, e_sd, e_dst, e_ctl);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      test_mul($urandom, $urandom, 1'($urandom), "mul_b2b");
    rand_inputs(7'h00);
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    rand_inputs(7'h00);
    bus.x_read_data_1 = 32'h1234; bus.x_reg_write = 1'b1; bus.x_dst_reg = 5'd7;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (!m_all_zero()) begin
      n_err++;
      $display("FAIL async_reset: got res=%h dst=%h ctl=%b want all 0",
               bus.m_alu_result, bus.m_dst_reg, m_ctrl());
    end
    @(negedge clock);
    reset = 1'b1;
    rand_inputs(7'h02);
    bus.x_read_data_1 = 32'd7; bus.x_read_data_2 = 32'd9; bus.x_alu_imm_src = 1'b0;
    repeat (11) @(negedge clock);
    reset = 1'b0;
    bus.x_read_data_1 = 32'd4; bus.x_read_data_2 = 32'd4;
    #1;
    n_cmp++;
    if (bus.x_stall !== 1'b0 || !m_all_zero()) begin
      n_err++;
      $display("FAIL mid_mul_reset: got stall=%b res=%h want 0 and m_* 0",
               bus.x_stall, bus.m_alu_result);
    end
    @(negedge clock);
    reset = 1'b1;
    test_mul(32'd4, 32'd4, 1'b0, "mul_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed_alu();
    test_alu_random();
    test_branch();
    test_mul(32'd7, 32'd6, 1'b0, "mul_7x6");
    test_mul(32'hFFFF_FFFF, 32'd3, 1'b0, "mul_neg1x3");
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
